pad_stream_gearbox: RTL and testbench
=====================================

# pad_stream_gearbox

Parametrised bidirectional stream adapter between the narrow user-area GPIO pad streams and the wider AXI4-Stream ports of the core datapath (spectrometer or successor). Ingress packs RATIO pad beats of PAD_W bits into one STREAM_W word and buffers words in a DEPTH-entry FIFO. Egress unpacks STREAM_W words into pad beats. A bypass mode carries one pad beat per word. It sits in user_project_wrapper between the io_in/io_out pad assignments and the core stream ports, replacing the fixed 8-bit-in/16-bit-out direct wiring.

## Interface
- PAD_W, 8, pad beat width in bits, both directions
- RATIO, 2, pad beats per stream word; ≥1
- STREAM_W, PAD_W*RATIO, core stream word width; derived, not overridable
- DEPTH, 4, ingress FIFO entries; power of 2, ≥2
- Clock and reset: one clock; reset is synchronous and active-low.
- wb_clk_i  in  1  sole clock, rising edge
- wb_rst_ni  in  1  synchronous active-low reset
- pack_en  in  1  1 = pack/unpack RATIO lanes, 0 = bypass (lane 0 only)
- pad_in_valid / pad_in_data / pad_in_last  in  1 / PAD_W / 1  ingress pad beat
- pad_in_ready  out  1  ingress beat accepted when valid&ready
- core_in_valid  out  1  packed word available
- core_in_data  out  STREAM_W  packed word, lane 0 = bits [PAD_W-1:0]
- core_in_keep  out  RATIO  per-lane valid mask
- core_in_last  out  1  final word of packet
- core_in_ready  in  1  core accepts word
- core_out_valid / core_out_data / core_out_last  in  1 / STREAM_W / 1  egress word from core
- core_out_ready  out  1  word accepted when valid&ready
- pad_out_valid / pad_out_data / pad_out_last  out  1 / PAD_W / 1  egress pad beat
- pad_out_ready  in  1  pad side accepts beat
- fifo_level  out  $clog2(DEPTH)+1  ingress FIFO occupancy

## Operation
- Mode register mode_q loads pack_en only when the ingress lane counter is 0, the FIFO is empty and the egress holding register is empty. Otherwise it holds. While mode_q=0, the effective ratio is 1.
- Ingress packer:
  - Lane counter in_lane (0..RATIO-1) and accumulation register.
  - On each accepted beat, data is written to lane in_lane.
  - The word completes when in_lane==RATIO-1 or pad_in_last=1. The completed word is pushed into the FIFO in the same cycle, with unwritten lanes zeroed, keep = lanes written (contiguous from lane 0), last = pad_in_last. in_lane then returns to 0.
  - Otherwise in_lane increments.
- pad_in_ready = !fifo_full. This applies even for non-final beats, and a push is refused while full even if a pop occurs in the same cycle.
- FIFO is a registered circular buffer with wrap-around pointers. Head drives core_in_*, with core_in_valid = !empty. Simultaneous push and pop while not full leaves fifo_level unchanged.
- Egress unpacker:
  - Holding register plus lane counter out_lane.
  - core_out_ready = !hold_v || (pad_out_ready && out_lane==eff_ratio-1), so a new word loads on the same cycle the last lane leaves.
  - pad_out_data = lane out_lane of the held word.
  - pad_out_last = held last && out_lane==eff_ratio-1.
  - Egress words are always full; there is no keep input.
- Reset: in_lane=0, out_lane=0, FIFO empty, hold_v=0, mode_q=1.

## Timing
- Reset values: pad_in_ready=0 during reset and 1 on the first cycle after. core_in_valid=0, core_in_data=0, core_in_keep=0, core_in_last=0, pad_out_valid=0, pad_out_data=0, pad_out_last=0, core_out_ready=0 during reset and 1 after, fifo_level=0.
- Ingress latency: a word appears on core_in_* 1 cycle after its completing pad beat is accepted.
- Egress latency: the first pad beat appears 1 cycle after the word is accepted. Throughput is 1 pad beat/cycle, with no bubble between words.
- A reset mid-packet discards the partial word, FIFO contents and the held word. No output glitches with valid=1.
- Handshakes follow AXI-Stream rules: data, keep and last are stable while valid=1 and ready=0, and valid is never withdrawn before acceptance.

## Test plan
- Pack, even packet: RATIO=2, beats 0x11,0x22,0x33,0x44 (last on 0x44) → words 0x2211 keep 2'b11 last 0, then 0x4433 keep 2'b11 last 1, each 1 cycle after its completing beat.
- Odd packet: beats 0x11,0x22,0x33 with last on 0x33 → 0x2211 keep 2'b11 last 0, then 0x0033 keep 2'b01 last 1. in_lane returns to 0.
- Backpressure and full: core_in_ready=0, 10 beats offered → exactly 8 accepted, fifo_level=4, pad_in_ready=0. Releasing ready drains in order with no loss, and pad_in_ready=1 on the cycle after the first pop.
- Egress: words 0xBEEF (last 0) then 0xCAFE (last 1), pad_out_ready=1 → pad beats 0xEF,0xBE,0xFE,0xCA on consecutive cycles, pad_out_last only on 0xCA. Toggling pad_out_ready holds the beat stable.
- Bypass: pack_en=0 while idle, beats 0xA5 (last) → word 0x00A5 keep 2'b01 last 1. Egress 0x1234 → single beat 0x34. A pack_en change mid-packet takes effect only after the packet drains.
- Reset mid-packet: wb_rst_ni=0 for 1 cycle after one beat → all outputs at reset values, fifo_level=0. A following clean packet packs from lane 0.

Source files
------------

// File: rtl/pad_stream_gearbox.sv
// Bidirectional pad <-> core stream gearbox: packs RATIO pad beats per core word on
// ingress (buffered in a DEPTH-entry FIFO) and unpacks core words into pad beats on egress.
module pad_stream_gearbox #(
   parameter  int PAD_W    = 8,
   parameter  int RATIO    = 2,
   parameter  int DEPTH    = 4,
   localparam int STREAM_W = PAD_W * RATIO,
   localparam int LVL_W    = $clog2(DEPTH) + 1
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_ni,
   input  logic                pack_en,
   input  logic                pad_in_valid,
   input  logic [PAD_W-1:0]    pad_in_data,
   input  logic                pad_in_last,
   output logic                pad_in_ready,
   output logic                core_in_valid,
   output logic [STREAM_W-1:0] core_in_data,
   output logic [RATIO-1:0]    core_in_keep,
   output logic                core_in_last,
   input  logic                core_in_ready,
   input  logic                core_out_valid,
   input  logic [STREAM_W-1:0] core_out_data,
   input  logic                core_out_last,
   output logic                core_out_ready,
   output logic                pad_out_valid,
   output logic [PAD_W-1:0]    pad_out_data,
   output logic                pad_out_last,
   input  logic                pad_out_ready,
   output logic [LVL_W-1:0]    fifo_level
);
   localparam int LANE_W = (RATIO > 1) ? $clog2(RATIO) : 1;
   localparam int AW     = $clog2(DEPTH);
   localparam int ENT_W  = STREAM_W + RATIO + 1;

   logic                run_r;
   logic                mode_r;
   logic                mode_s;
   logic                idle_s;
   logic [LANE_W-1:0]   last_idx_s;
   logic [LANE_W-1:0]   in_lane_r;
   logic [STREAM_W-1:0] acc_r;
   logic [STREAM_W-1:0] word_s;
   logic [RATIO-1:0]    keep_s;
   logic                accept_s;
   logic                complete_s;
   logic                pop_s;
   logic [ENT_W-1:0]    mem_r [DEPTH];
   logic [ENT_W-1:0]    head_s;
   logic [AW:0]         wr_ptr_r;
   logic [AW:0]         rd_ptr_r;
   logic [AW:0]         level_s;
   logic                full_s;
   logic                empty_s;
   logic [STREAM_W-1:0] hold_data_r;
   logic                hold_last_r;
   logic                hold_v_r;
   logic [LANE_W-1:0]   out_lane_r;
   logic                out_last_lane_s;
   logic                load_s;
   logic                beat_s;

   // The mode may only change with both directions idle; an idle cycle already uses the new mode.
   assign idle_s     = (in_lane_r == {LANE_W{1'b0}}) && empty_s && !hold_v_r;
   assign mode_s     = idle_s ? pack_en : mode_r;
   assign last_idx_s = mode_s ? LANE_W'(RATIO - 1) : {LANE_W{1'b0}};

   assign level_s    = wr_ptr_r - rd_ptr_r;
   assign full_s     = (level_s == (AW + 1)'(DEPTH));
   assign empty_s    = (level_s == {(AW + 1){1'b0}});
   assign fifo_level = level_s;

   assign pad_in_ready = run_r && !full_s;
   assign accept_s     = pad_in_valid && pad_in_ready;
   assign complete_s   = accept_s && ((in_lane_r == last_idx_s) || pad_in_last);
   assign pop_s        = !empty_s && core_in_ready;

   assign head_s        = mem_r[rd_ptr_r[AW-1:0]];
   assign core_in_valid = !empty_s;
   assign core_in_data  = empty_s ? {STREAM_W{1'b0}} : head_s[STREAM_W-1:0];
   assign core_in_keep  = empty_s ? {RATIO{1'b0}} : head_s[STREAM_W +: RATIO];
   assign core_in_last  = !empty_s && head_s[ENT_W-1];

   assign out_last_lane_s = (out_lane_r == last_idx_s);
   assign core_out_ready  = run_r && (!hold_v_r || (pad_out_ready && out_last_lane_s));
   assign load_s          = core_out_valid && core_out_ready;
   assign beat_s          = hold_v_r && pad_out_ready;
   assign pad_out_valid   = hold_v_r;
   assign pad_out_data    = hold_v_r ? hold_data_r[int'(out_lane_r) * PAD_W +: PAD_W] : {PAD_W{1'b0}};
   assign pad_out_last    = hold_v_r && hold_last_r && out_last_lane_s;

   // Merge the incoming beat into its lane; lanes above in_lane are still zero in acc_r.
   always_comb begin
      word_s = acc_r;
      keep_s = {RATIO{1'b0}};
      for (int k = 0; k < RATIO; k++) begin
         if (LANE_W'(k) == in_lane_r) begin
            word_s[k*PAD_W +: PAD_W] = pad_in_data;
         end else begin
            word_s[k*PAD_W +: PAD_W] = acc_r[k*PAD_W +: PAD_W];
         end
         keep_s[k] = (LANE_W'(k) <= in_lane_r);
      end
   end

   // Run flag, mode register and ingress lane accumulation.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         run_r     <= 1'b0;
         mode_r    <= 1'b1;
         in_lane_r <= {LANE_W{1'b0}};
         acc_r     <= {STREAM_W{1'b0}};
      end else begin
         run_r  <= 1'b1;
         mode_r <= mode_s;
         if (complete_s) begin
            in_lane_r <= {LANE_W{1'b0}};
            acc_r     <= {STREAM_W{1'b0}};
         end else if (accept_s) begin
            in_lane_r <= in_lane_r + LANE_W'(1);
            acc_r     <= word_s;
         end
      end
   end

   // FIFO storage; contents are masked at the output while empty so no reset is needed.
   always_ff @(posedge wb_clk_i) begin
      if (complete_s) begin
         mem_r[wr_ptr_r[AW-1:0]] <= {pad_in_last, keep_s, word_s};
      end
   end

   // FIFO pointers with one extra wrap bit to tell full from empty.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         wr_ptr_r <= {(AW + 1){1'b0}};
         rd_ptr_r <= {(AW + 1){1'b0}};
      end else begin
         if (complete_s) begin
            wr_ptr_r <= wr_ptr_r + (AW + 1)'(1);
         end
         if (pop_s) begin
            rd_ptr_r <= rd_ptr_r + (AW + 1)'(1);
         end
      end
   end

   // Egress holding register; a new word loads in the cycle its predecessor's last lane leaves.
   always_ff @(posedge wb_clk_i) begin
      if (!wb_rst_ni) begin
         hold_data_r <= {STREAM_W{1'b0}};
         hold_last_r <= 1'b0;
         hold_v_r    <= 1'b0;
         out_lane_r  <= {LANE_W{1'b0}};
      end else if (load_s) begin
         hold_data_r <= core_out_data;
         hold_last_r <= core_out_last;
         hold_v_r    <= 1'b1;
         out_lane_r  <= {LANE_W{1'b0}};
      end else if (beat_s) begin
         if (out_last_lane_s) begin
            hold_v_r   <= 1'b0;
            out_lane_r <= {LANE_W{1'b0}};
         end else begin
            out_lane_r <= out_lane_r + LANE_W'(1);
         end
      end
   end
endmodule

// File: tb/tb_pad_stream_gearbox.sv
// Directed and randomized bench for pad_stream_gearbox; randomized traffic is checked
// against packet-level expectations built by chunking beats / splitting words.
module tb_pad_stream_gearbox;
   localparam int PAD_W = 8;
   localparam int RATIO = 2;
   localparam int DEPTH = 4;

   typedef struct packed {logic [7:0] d; logic l;} beat_t;
   typedef struct packed {logic l; logic [1:0] k; logic [15:0] d;} word_t;
   typedef struct packed {logic l; logic [15:0] d;} oword_t;

   logic        clk = 1'b0;
   logic        rst_n, pack_en;
   logic        pad_in_valid, pad_in_last, pad_in_ready;
   logic [7:0]  pad_in_data;
   logic        core_in_valid, core_in_last, core_in_ready;
   logic [15:0] core_in_data;
   logic [1:0]  core_in_keep;
   logic        core_out_valid, core_out_last, core_out_ready;
   logic [15:0] core_out_data;
   logic        pad_out_valid, pad_out_last, pad_out_ready;
   logic [7:0]  pad_out_data;
   logic [2:0]  fifo_level;

   int checks = 0;
   int errors = 0;

   beat_t  in_q[$];
   word_t  exp_w[$];
   oword_t out_q[$];
   beat_t  exp_b[$];

   always #5 clk = ~clk;

   pad_stream_gearbox #(.PAD_W(PAD_W), .RATIO(RATIO), .DEPTH(DEPTH)) dut (
      .wb_clk_i(clk), .wb_rst_ni(rst_n), .pack_en(pack_en),
      .pad_in_valid(pad_in_valid), .pad_in_data(pad_in_data), .pad_in_last(pad_in_last),
      .pad_in_ready(pad_in_ready),
      .core_in_valid(core_in_valid), .core_in_data(core_in_data), .core_in_keep(core_in_keep),
      .core_in_last(core_in_last), .core_in_ready(core_in_ready),
      .core_out_valid(core_out_valid), .core_out_data(core_out_data), .core_out_last(core_out_last),
      .core_out_ready(core_out_ready),
      .pad_out_valid(pad_out_valid), .pad_out_data(pad_out_data), .pad_out_last(pad_out_last),
      .pad_out_ready(pad_out_ready), .fifo_level(fifo_level)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
         $error("%s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [7:0] d, input logic l);
      pad_in_valid = 1'b1;
      pad_in_data  = d;
      pad_in_last  = l;
      #1;
      chk("send_ready", 32'(pad_in_ready), 32'd1);
      tick();
      pad_in_valid = 1'b0;
      pad_in_last  = 1'b0;
   endtask

   task automatic chk_word(input string tag, input logic [15:0] d, input logic [1:0] k, input logic l);
      chk(tag, 32'({core_in_valid, core_in_last, core_in_keep, core_in_data}), 32'({1'b1, l, k, d}));
   endtask

   task automatic chk_beat(input string tag, input logic [7:0] d, input logic l);
      chk(tag, 32'({pad_out_valid, pad_out_last, pad_out_data}), 32'({1'b1, l, d}));
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_pad_in_ready"}, 32'(pad_in_ready), 32'd0);
      chk({tag, "_core_out_ready"}, 32'(core_out_ready), 32'd0);
      chk({tag, "_core_in"}, 32'({core_in_valid, core_in_last, core_in_keep, core_in_data}), 32'd0);
      chk({tag, "_pad_out"}, 32'({pad_out_valid, pad_out_last, pad_out_data}), 32'd0);
      chk({tag, "_fifo_level"}, 32'(fifo_level), 32'd0);
   endtask

   // Packet of len random beats; expected words are consecutive groups of r beats.
   task automatic add_packet(input int len, input bit pk);
      int    r;
      beat_t b[$];
      r = pk ? RATIO : 1;
      for (int i = 0; i < len; i++) begin
         beat_t x;
         x.d = 8'($urandom);
         x.l = (i == len - 1);
         b.push_back(x);
         in_q.push_back(x);
      end
      for (int i = 0; i < len; i += r) begin
         word_t w;
         w = '0;
         for (int j = 0; j < r && i + j < len; j++) begin
            w.d[8*j +: 8] = b[i+j].d;
            w.k[j]        = 1'b1;
         end
         w.l = (i + r >= len);
         exp_w.push_back(w);
      end
   endtask

   task automatic add_word(input bit pk);
      oword_t w;
      int     r;
      r   = pk ? RATIO : 1;
      w.d = 16'($urandom);
      w.l = ($urandom_range(2) == 0);
      out_q.push_back(w);
      for (int j = 0; j < r; j++) begin
         beat_t x;
         x.d = w.d[8*j +: 8];
         x.l = w.l && (j == r - 1);
         exp_b.push_back(x);
      end
   endtask

   // Drive both directions from the queues with random valid/ready until everything drains.
   task automatic run(input int budget, input int vp, input int rp);
      int          cyc = 0;
      logic        prev_istall = 1'b0, prev_ostall = 1'b0;
      logic [18:0] prev_iw = '0;
      logic [9:0]  prev_ob = '0;
      logic        hs_in, hs_out;
      word_t       w;
      beat_t       b;
      while ((in_q.size() + exp_w.size() + out_q.size() + exp_b.size()) != 0 && cyc < budget) begin
         if (!pad_in_valid && in_q.size() != 0 && $urandom_range(99) < vp) pad_in_valid = 1'b1;
         if (pad_in_valid) begin
            pad_in_data = in_q[0].d;
            pad_in_last = in_q[0].l;
         end
         if (!core_out_valid && out_q.size() != 0 && $urandom_range(99) < vp) core_out_valid = 1'b1;
         if (core_out_valid) begin
            core_out_data = out_q[0].d;
            core_out_last = out_q[0].l;
         end
         core_in_ready = ($urandom_range(99) < rp);
         pad_out_ready = ($urandom_range(99) < rp);
         #1;
         if (prev_istall)
            chk("core_in_stable", 32'({core_in_valid, core_in_last, core_in_keep, core_in_data}), 32'({1'b1, prev_iw}));
         if (prev_ostall)
            chk("pad_out_stable", 32'({pad_out_valid, pad_out_last, pad_out_data}), 32'(prev_ob));
         if (core_in_valid && core_in_ready) begin
            chk("core_in_expected", 32'(exp_w.size() != 0), 32'd1);
            if (exp_w.size() != 0) begin
               w = exp_w.pop_front();
               chk("core_in_word", 32'({core_in_last, core_in_keep, core_in_data}), 32'(w));
            end
         end
         if (pad_out_valid && pad_out_ready) begin
            chk("pad_out_expected", 32'(exp_b.size() != 0), 32'd1);
            if (exp_b.size() != 0) begin
               b = exp_b.pop_front();
               chk("pad_out_beat", 32'({pad_out_data, pad_out_last}), 32'(b));
            end
         end
         prev_istall = core_in_valid && !core_in_ready;
         prev_iw     = {core_in_last, core_in_keep, core_in_data};
         prev_ostall = pad_out_valid && !pad_out_ready;
         prev_ob     = {pad_out_valid, pad_out_last, pad_out_data};
         hs_in  = pad_in_valid && pad_in_ready;
         hs_out = core_out_valid && core_out_ready;
         tick();
         cyc++;
         if (hs_in) begin
            void'(in_q.pop_front());
            pad_in_valid = 1'b0;
         end
         if (hs_out) begin
            void'(out_q.pop_front());
            core_out_valid = 1'b0;
         end
      end
      chk("drain_ingress", 32'(in_q.size() + exp_w.size()), 32'd0);
      chk("drain_egress", 32'(out_q.size() + exp_b.size()), 32'd0);
      in_q.delete(); exp_w.delete(); out_q.delete(); exp_b.delete();
      pad_in_valid = 1'b0; core_out_valid = 1'b0;
      core_in_ready = 1'b1; pad_out_ready = 1'b1;
      tick();
   endtask

   initial begin
      int acc_n, k;
      logic hs;
      rst_n = 1'b0; pack_en = 1'b1;
      pad_in_valid = 1'b0; pad_in_data = '0; pad_in_last = 1'b0;
      core_in_ready = 1'b1;
      core_out_valid = 1'b0; core_out_data = '0; core_out_last = 1'b0;
      pad_out_ready = 1'b1;
      tick(); tick();
      chk_reset_outputs("reset");
      rst_n = 1'b1;
      tick();
      chk("post_reset_pad_in_ready", 32'(pad_in_ready), 32'd1);
      chk("post_reset_core_out_ready", 32'(core_out_ready), 32'd1);

      // even packet
      send(8'h11, 1'b0); chk("even_no_word", 32'(core_in_valid), 32'd0);
      send(8'h22, 1'b0); chk_word("even_w0", 16'h2211, 2'b11, 1'b0);
      send(8'h33, 1'b0); chk("even_popped", 32'(core_in_valid), 32'd0);
      send(8'h44, 1'b1); chk_word("even_w1", 16'h4433, 2'b11, 1'b1);
      tick(); chk("even_empty", 32'({core_in_valid, fifo_level}), 32'd0);

      // odd packet, then a fresh packet must start at lane 0
      send(8'h11, 1'b0); send(8'h22, 1'b0); chk_word("odd_w0", 16'h2211, 2'b11, 1'b0);
      send(8'h33, 1'b1); chk_word("odd_w1", 16'h0033, 2'b01, 1'b1);
      send(8'h77, 1'b0); chk("odd_lane0", 32'(core_in_valid), 32'd0);
      send(8'h88, 1'b1); chk_word("odd_next", 16'h8877, 2'b11, 1'b1);
      tick();

      // backpressure until full
      core_in_ready = 1'b0; acc_n = 0; k = 1;
      for (int c = 0; c < 12; c++) begin
         pad_in_valid = 1'b1; pad_in_data = 8'(k); pad_in_last = (k == 10);
         #1;
         hs = pad_in_ready;
         tick();
         if (hs) begin acc_n++; k++; end
      end
      chk("full_accepted", 32'(acc_n), 32'd8);
      chk("full_level", 32'(fifo_level), 32'd4);
      chk("full_ready", 32'(pad_in_ready), 32'd0);
      core_in_ready = 1'b1;
      #1;
      chk("full_pop_cycle_ready", 32'(pad_in_ready), 32'd0);
      chk_word("full_head", 16'h0201, 2'b11, 1'b0);
      tick();
      chk("full_after_pop_ready", 32'(pad_in_ready), 32'd1);
      chk("full_after_pop_level", 32'(fifo_level), 32'd3);
      in_q.push_back('{d: 8'h09, l: 1'b0});
      in_q.push_back('{d: 8'h0a, l: 1'b1});
      exp_w.push_back('{l: 1'b0, k: 2'b11, d: 16'h0403});
      exp_w.push_back('{l: 1'b0, k: 2'b11, d: 16'h0605});
      exp_w.push_back('{l: 1'b0, k: 2'b11, d: 16'h0807});
      exp_w.push_back('{l: 1'b1, k: 2'b11, d: 16'h0a09});
      run(200, 100, 100);

      // egress unpacking with a pad-side stall
      core_out_valid = 1'b1; core_out_data = 16'hBEEF; core_out_last = 1'b0;
      #1; chk("eg_ready_idle", 32'(core_out_ready), 32'd1);
      tick();
      core_out_data = 16'hCAFE; core_out_last = 1'b1;
      #1;
      chk_beat("eg_b0", 8'hEF, 1'b0);
      chk("eg_busy", 32'(core_out_ready), 32'd0);
      tick();
      chk_beat("eg_b1", 8'hBE, 1'b0);
      chk("eg_reload_ready", 32'(core_out_ready), 32'd1);
      tick();
      core_out_valid = 1'b0;
      chk_beat("eg_b2", 8'hFE, 1'b0);
      pad_out_ready = 1'b0;
      tick();
      chk_beat("eg_b2_held", 8'hFE, 1'b0);
      pad_out_ready = 1'b1;
      tick();
      chk_beat("eg_b3", 8'hCA, 1'b1);
      tick();
      chk("eg_done", 32'(pad_out_valid), 32'd0);

      // bypass
      pack_en = 1'b0; tick();
      send(8'hA5, 1'b1); chk_word("byp_in", 16'h00A5, 2'b01, 1'b1);
      tick();
      core_out_valid = 1'b1; core_out_data = 16'h1234; core_out_last = 1'b1;
      tick();
      core_out_valid = 1'b0;
      chk_beat("byp_out", 8'h34, 1'b1);
      tick();
      chk("byp_out_single", 32'(pad_out_valid), 32'd0);

      // mode change requested mid-packet applies only once idle
      pack_en = 1'b1; tick();
      send(8'h11, 1'b0);
      pack_en = 1'b0;
      send(8'h22, 1'b1); chk_word("mode_hold", 16'h2211, 2'b11, 1'b1);
      tick();
      send(8'h5A, 1'b0); chk_word("mode_new0", 16'h005A, 2'b01, 1'b0);
      send(8'h5B, 1'b1); chk_word("mode_new1", 16'h005B, 2'b01, 1'b1);
      tick();
      pack_en = 1'b1; tick();

      // reset mid-packet with FIFO contents and a held egress word
      core_in_ready = 1'b0;
      send(8'h11, 1'b0); send(8'h22, 1'b0);
      core_out_valid = 1'b1; core_out_data = 16'hABCD; core_out_last = 1'b0;
      send(8'h33, 1'b0);
      core_out_valid = 1'b0;
      rst_n = 1'b0;
      tick();
      chk_reset_outputs("midrst");
      rst_n = 1'b1; core_in_ready = 1'b1;
      tick();
      send(8'h66, 1'b0); send(8'h77, 1'b1);
      chk_word("midrst_clean", 16'h7766, 2'b11, 1'b1);
      chk("midrst_no_egress", 32'(pad_out_valid), 32'd0);
      tick();

      // randomized traffic in both modes
      for (int m = 0; m < 2; m++) begin
         pack_en = (m == 0);
         tick(); tick();
         for (int p = 0; p < 15; p++) add_packet($urandom_range(7, 1), (m == 0));
         for (int p = 0; p < 15; p++) add_word(m == 0);
         run(6000, 60, 60);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
